// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between instruction fetch and data access, data first.
// Define MEM_ARB_STARVE_GUARD_EN to force a pending fetch through after IWAIT_MAX data grants.
module memory_arbiter #(
    parameter int IWAIT_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic [1:0]  ramstate,
    input  logic [31:0] ramload,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        memerr
);
    localparam logic [1:0] ACCESS = 2'd2, ERROR = 2'd3;

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

    state_t      state_q;
    logic [31:0] addr_q, store_q;
    logic        ren_q, wen_q;
    logic        dreq, done, ok, dwin, ifrc;

    if (IWAIT_MAX < 1) begin : g_bad_param
        $error("IWAIT_MAX must be at least 1");
    end

    assign dreq = dREN | dWEN;
    assign ok   = ramstate == ACCESS;
    assign done = (state_q != IDLE) && (ok || ramstate == ERROR);
    assign dwin = dreq && !ifrc;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(IWAIT_MAX + 1);
    logic [CW-1:0] starve_q;
    assign ifrc = iREN && starve_q == CW'(IWAIT_MAX);
    // Counts data grants that bypassed a waiting fetch; never exceeds IWAIT_MAX.
    always_ff @(posedge CLK) begin
        if (RST) starve_q <= '0;
        else if (state_q == IDLE && iREN) starve_q <= dwin ? starve_q + 1'b1 : '0;
    end
`else
    assign ifrc = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            store_q <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
        end else if (state_q == IDLE) begin
            if (dwin) begin
                state_q <= DBUSY;
                addr_q  <= daddr;
                store_q <= dstore;
                ren_q   <= !dWEN;
                wen_q   <= dWEN;
            end else if (iREN) begin
                state_q <= IBUSY;
                addr_q  <= iaddr;
                ren_q   <= 1'b1;
            end
        end else if (done) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
        end
    end

    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = (state_q == IDLE) ? '0 : addr_q;
    assign ramstore = (state_q == DBUSY) ? store_q : '0;
    assign iwait    = iREN && !(state_q == IBUSY && done);
    assign dwait    = dreq && !(state_q == DBUSY && done);
    // A requester that dropped its request mid-transaction gets nothing back.
    assign iload    = (state_q == IBUSY && ok && iREN) ? ramload : '0;
    assign dload    = (state_q == DBUSY && ok && dreq) ? ramload : '0;
    assign memerr   = done && ramstate == ERROR;
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequential arbiter that shares the single RAM port between the request unit's instruction-fetch and data-access requests. It sits between the request/cache side (iREN, dREN, dWEN, iaddr, daddr) and the RAM model (ramREN, ramWEN, ramaddr, ramstate). It holds each granted transaction until RAM reports completion and returns per-side wait/load signals. Data requests win by default; an optional starvation guard bounds how long instruction fetch can be deferred.

## Interface
- IWAIT_MAX, default 4: maximum consecutive data grants made over a pending fetch before the fetch is forced through. Used only when MEM_ARB_STARVE_GUARD_EN is defined.
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- iREN  input  1  instruction read request; held until iwait is low.
- iaddr  input  32  instruction word address.
- dREN  input  1  data read request; held until dwait is low.
- dWEN  input  1  data write request; held until dwait is low.
- daddr  input  32  data address.
- dstore  input  32  data write value.
- ramstate  input  2  ramstate_t from cpu_types_pkg: FREE, BUSY, ACCESS, ERROR.
- ramload  input  32  RAM read data; valid when ramstate is ACCESS.
- iwait  output  1  instruction side must hold its request.
- dwait  output  1  data side must hold its request.
- iload  output  32  fetched instruction.
- dload  output  32  loaded data.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- ramaddr  output  32  RAM address.
- ramstore  output  32  RAM write data.
- memerr  output  1  one-cycle pulse when a transaction completes with ramstate ERROR.

## Operation
- FSM states: IDLE, IBUSY, DBUSY.
- IDLE:
  - Sample requests.
  - If dREN or dWEN is high and the data side wins, latch daddr, dstore and op (write if dWEN, else read), then go to DBUSY.
  - Else if iREN is high, latch iaddr and go to IBUSY.
  - Else stay in IDLE.
  - RAM outputs are inactive: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- IBUSY: ramREN=1, ramaddr=latched iaddr.
  - On ACCESS or ERROR: transaction is done. Go to IDLE.
  - On FREE or BUSY: stay.
- DBUSY: ramREN or ramWEN per the latched op; ramaddr and ramstore from the latches. Done and exit rules are the same as IBUSY.
- dREN and dWEN both high: treated as a write.
- Completion outputs:
  - iwait = iREN AND NOT (IBUSY AND done).
  - dwait = (dREN OR dWEN) AND NOT (DBUSY AND done).
  - iload and dload pass ramload through when their side completes on ACCESS. They are 0 on ERROR and 0 at all other times.
  - memerr = done AND ramstate==ERROR.
- Abandoned request: if a requester drops its request while its transaction is in BUSY, the RAM transaction still runs to completion. The result is discarded and the FSM returns to IDLE.
- Latches are written only when leaving IDLE. Changes to request-side inputs while busy have no effect on the RAM port.

## Timing
- Reset (RST high at an edge): state becomes IDLE, latches clear to 0, starvation counter clears to 0.
- Output values while in reset/IDLE: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0, memerr=0. iwait and dwait follow their request inputs (combinational).
- RST asserted mid-transaction aborts immediately. RAM enables drop in the cycle after the edge.
- Latency: request high in IDLE at cycle N gives BUSY at N+1. If ramstate is ACCESS at N+1, wait drops at N+1 and the requester advances at the N+2 edge.
- Minimum latency is 2 cycles. Each RAM wait-state cycle adds 1.
- There is always one IDLE cycle between back-to-back transactions.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A counter of width $clog2(IWAIT_MAX+1) increments on each data grant made while iREN is high.
  - The counter clears on any instruction grant and on reset.
  - When the counter equals IWAIT_MAX and iREN is high in IDLE, the instruction side wins even if a data request is pending.
- MEM_ARB_STARVE_GUARD_EN undefined: no counter. The data side always wins in IDLE, and IWAIT_MAX is ignored.

## Test plan
- Lone fetch: iREN=1, iaddr=0x40, ramstate ACCESS in the first BUSY cycle with ramload=0x8C220004.
  - Required: iwait low in cycle 2, iload=0x8C220004, then IDLE.
- Simultaneous iREN and dWEN, daddr=0x100, dstore=0xDEADBEEF.
  - Required: data granted first (ramWEN=1, ramaddr=0x100). The fetch is granted after one IDLE cycle.
- Wait states: ramstate BUSY for 3 cycles then ACCESS on a dREN.
  - Required: dwait high for 4 cycles, dload valid only in the ACCESS cycle.
- Starvation guard (defined, IWAIT_MAX=4): iREN held with 6 back-to-back data requests.
  - Required: 4 data grants, then the instruction grant, then the remaining data.
  - Undefined build: all 6 data grants come first.
- ERROR on a read.
  - Required: memerr pulses once, dload=0, dwait low that cycle.
- RST raised during DBUSY.
  - Required: ramWEN=0 next cycle, FSM in IDLE, a new request is served normally.
